mic1_mem_if: RTL and testbench

MIC1_MEM_IF -- requirements
Module: mic1_mem_if

---
 rtl/mic1_pkg.sv | 23 ++
 rtl/mic1_mem_if_if.sv | 23 ++
 rtl/mic1_mem_stage.sv | 33 +++
 rtl/mic1_mem_if.sv | 96 +++++++++
 tb/tb_mic1_mem_if.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mic1_pkg.sv
// Shared constants for the MIC-1 memory interface: MIR memory-control bit
// positions and the big-endian byte-lane selection used by the fetch path.
package mic1_pkg;

   localparam int MEM_WRITE = 6;
   localparam int MEM_READ  = 5;
   localparam int MEM_FETCH = 4;

   // mem_ctl carries MIR[6:4], so bit positions are rebased onto MEM_FETCH
   localparam int CTL_WRITE = MEM_WRITE - MEM_FETCH;
   localparam int CTL_READ  = MEM_READ  - MEM_FETCH;
   localparam int CTL_FETCH = MEM_FETCH - MEM_FETCH;

   localparam int BYTE_W    = 8;
   localparam int NUM_LANES = 4;

   // pc[1:0] = 0 selects the most significant byte of the word
   function automatic logic [BYTE_W-1:0] mbr_byte(input logic [31:0] word,
                                                  input logic [1:0]  sel);
      return word[BYTE_W*(NUM_LANES-1-int'(sel)) +: BYTE_W];
   endfunction

endpackage

// File: rtl/mic1_mem_if_if.sv
// Data-RAM and program-ROM port bundle between the memory interface and the
// synchronous memories (one-cycle read latency on both).
interface mic1_mem_bus #(
   parameter int RAM_AW = 30,
   parameter int ROM_AW = 32
);
   logic [RAM_AW-1:0] ram_address;
   logic [31:0]       ram_data;
   logic              ram_wren;
   logic [31:0]       ram_q;
   logic [ROM_AW-1:0] rom_address;
   logic [31:0]       rom_q;

   modport master (
      output ram_address, ram_data, ram_wren, rom_address,
      input  ram_q, rom_q
   );

   modport slave (
      input  ram_address, ram_data, ram_wren, rom_address,
      output ram_q, rom_q
   );
endinterface

// File: rtl/mic1_mem_stage.sv
// Two-deep valid/tag shift pipeline tracking a request from issue edge to
// the cycle its memory data is valid.
module mic1_mem_stage #(
   parameter int TAG_W = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_vld,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_vld,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int STAGES = 2;

   logic [STAGES:1]            vld_pipe;
   logic [STAGES:1][TAG_W-1:0] tag_pipe;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
         tag_pipe <= {tag_pipe[STAGES-1:1], in_tag};
      end
   end

   assign out_vld = vld_pipe[STAGES];
   assign out_tag = tag_pipe[STAGES];
   assign busy    = |vld_pipe;

endmodule

// File: rtl/mic1_mem_if.sv
// MIC-1 memory interface: registers MAR/MDR/PC requests onto the RAM/ROM
// ports and returns read data to MDR and fetched bytes to MBR two cycles later.
module mic1_mem_if
   import mic1_pkg::*;
#(
   parameter int RAM_AW = 30,
   parameter int ROM_AW = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [2:0]        mem_ctl,
   input  logic [31:0]       mar,
   input  logic [31:0]       mdr,
   input  logic [31:0]       pc,
   mic1_mem_bus.master       mem,
   output logic              mdr_load,
   output logic [31:0]       mdr_in,
   output logic              mbr_load,
   output logic [7:0]        mbr_in,
   output logic              busy,
   output logic              rw_conflict
);
   logic wr_req, rd_req, fe_req;
   logic rd_vld, rd_busy, fe_vld, fe_busy;
   logic [1:0] fe_sel;
   logic       unused_rd_tag;

   // Zero-extended so any RAM_AW/ROM_AW slices cleanly out of 32-bit inputs
   logic [RAM_AW+31:0] mar_ext;
   logic [ROM_AW+31:0] pc_ext;
   logic               unused_ok;

   logic [RAM_AW-1:0] ram_addr_q;
   logic [31:0]       ram_data_q;
   logic              ram_wren_q;
   logic [ROM_AW-1:0] rom_addr_q;

   assign mar_ext   = {{RAM_AW{1'b0}}, mar};
   assign pc_ext    = {{ROM_AW{1'b0}}, pc};
   assign unused_ok = ^{mar_ext, pc_ext, unused_rd_tag};

   // A simultaneous write drops the read
   assign wr_req = mem_ctl[CTL_WRITE];
   assign rd_req = mem_ctl[CTL_READ] & ~wr_req;
   assign fe_req = mem_ctl[CTL_FETCH];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         ram_wren_q  <= 1'b0;
         rom_addr_q  <= '0;
         rw_conflict <= 1'b0;
      end else begin
         ram_addr_q <= mar_ext[RAM_AW-1:0];
         ram_data_q <= mdr;
         ram_wren_q <= wr_req;
         rom_addr_q <= pc_ext[ROM_AW+1:2];
         if (wr_req && mem_ctl[CTL_READ])
            rw_conflict <= 1'b1;
      end
   end

   assign mem.ram_address = ram_addr_q;
   assign mem.ram_data    = ram_data_q;
   assign mem.ram_wren    = ram_wren_q;
   assign mem.rom_address = rom_addr_q;

   mic1_mem_stage #(.TAG_W(1)) u_rd_stage (
      .clock   (clock),
      .reset   (reset),
      .in_vld  (rd_req),
      .in_tag  (1'b0),
      .out_vld (rd_vld),
      .out_tag (unused_rd_tag),
      .busy    (rd_busy)
   );

   // Byte select rides along with the fetch so it lines up with rom_q
   mic1_mem_stage #(.TAG_W(2)) u_fe_stage (
      .clock   (clock),
      .reset   (reset),
      .in_vld  (fe_req),
      .in_tag  (pc[1:0]),
      .out_vld (fe_vld),
      .out_tag (fe_sel),
      .busy    (fe_busy)
   );

   assign mdr_load = rd_vld;
   assign mdr_in   = rd_vld ? mem.ram_q : '0;
   assign mbr_load = fe_vld;
   assign mbr_in   = fe_vld ? mbr_byte(mem.rom_q, fe_sel) : '0;
   assign busy     = rd_busy | fe_busy;

endmodule

// File: tb/tb_mic1_mem_if.sv
// Randomized bench for mic1_mem_if: behavioural per-cycle expectation tables
// filled at issue time, checked every cycle, plus directed literal scenarios.
module tb_mic1_mem_if;
   localparam int NCYC = 1024;

   logic        clock;
   logic        reset;
   logic [2:0]  mem_ctl;
   logic [31:0] mar, mdr, pc;
   logic        mdr_load, mbr_load, busy, rw_conflict;
   logic [31:0] mdr_in;
   logic [7:0]  mbr_in;

   mic1_mem_bus #(.RAM_AW(30), .ROM_AW(32)) bus ();

   mic1_mem_if #(.RAM_AW(30), .ROM_AW(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_ctl     (mem_ctl),
      .mar         (mar),
      .mdr         (mdr),
      .pc          (pc),
      .mem         (bus),
      .mdr_load    (mdr_load),
      .mdr_in      (mdr_in),
      .mbr_load    (mbr_load),
      .mbr_in      (mbr_in),
      .busy        (busy),
      .rw_conflict (rw_conflict)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   bit run_cmp = 0;

   function automatic logic [31:0] ram_init(input logic [29:0] a);
      return {2'b10, a} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'd8) return 32'h1122_3344;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Environment memories: synchronous, one-cycle read latency
   logic [31:0] tb_ram [logic [29:0]];
   always @(posedge clock) begin
      bus.ram_q <= tb_ram.exists(bus.ram_address) ? tb_ram[bus.ram_address]
                                                  : ram_init(bus.ram_address);
      if (bus.ram_wren) tb_ram[bus.ram_address] = bus.ram_data;
      bus.rom_q <= rom_word(bus.rom_address);
   end

   // Reference model: expected outputs per cycle, filled when a request issues
   logic [31:0] model_ram [logic [29:0]];
   bit          e_mdr_ld [NCYC];
   logic [31:0] e_mdr    [NCYC];
   bit          e_mbr_ld [NCYC];
   logic [7:0]  e_mbr    [NCYC];
   bit          e_wren   [NCYC];
   logic [31:0] e_wdata  [NCYC];
   bit          e_ra_v   [NCYC];
   logic [29:0] e_ra     [NCYC];
   bit          e_rom_v  [NCYC];
   logic [31:0] e_rom    [NCYC];
   bit          e_busy   [NCYC];
   int          conflict_from = NCYC + 10;

   function automatic logic [31:0] model_rd(input logic [29:0] a);
      return model_ram.exists(a) ? model_ram[a] : ram_init(a);
   endfunction

   task automatic model_issue(input int k, input logic [2:0] ctl,
                              input logic [31:0] m, d, p);
      logic [31:0] w;
      bit wr, rd, fe;
      wr = ctl[2];
      rd = ctl[1] && !ctl[2];
      fe = ctl[0];
      if (wr || rd) begin e_ra_v[k+1] = 1; e_ra[k+1] = m[29:0]; end
      if (wr) begin
         e_wren[k+1]  = 1;
         e_wdata[k+1] = d;
         model_ram[m[29:0]] = d;
      end
      if (ctl[2] && ctl[1] && conflict_from > k+1) conflict_from = k+1;
      if (rd) begin
         e_mdr_ld[k+2] = 1;
         e_mdr[k+2]    = model_rd(m[29:0]);
         e_busy[k+1]   = 1;
         e_busy[k+2]   = 1;
      end
      if (fe) begin
         e_rom_v[k+1] = 1;
         e_rom[k+1]   = {2'b00, p[31:2]};
         w = rom_word({2'b00, p[31:2]});
         e_mbr_ld[k+2] = 1;
         e_mbr[k+2]    = 8'((w >> (8 * (3 - int'(p[1:0])))) & 32'hFF);
         e_busy[k+1]   = 1;
         e_busy[k+2]   = 1;
      end
   endtask

   task automatic model_reset();
      for (int i = cyc + 1; i < NCYC; i++) begin
         e_mdr_ld[i] = 0; e_mdr[i] = '0; e_mbr_ld[i] = 0; e_mbr[i] = '0;
         e_wren[i] = 0; e_wdata[i] = '0; e_ra_v[i] = 0; e_ra[i] = '0;
         e_rom_v[i] = 0; e_rom[i] = '0; e_busy[i] = 0;
      end
      conflict_from = NCYC + 10;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
   endtask

   // Per-cycle compare against the model, sampled mid-cycle
   always @(negedge clock) begin
      if (run_cmp && reset && cyc > 0 && cyc < NCYC) begin
         chk("mdr_load", 32'(mdr_load), 32'(e_mdr_ld[cyc]));
         chk("mdr_in",   mdr_in, e_mdr_ld[cyc] ? e_mdr[cyc] : 32'h0);
         chk("mbr_load", 32'(mbr_load), 32'(e_mbr_ld[cyc]));
         chk("mbr_in",   32'(mbr_in), e_mbr_ld[cyc] ? 32'(e_mbr[cyc]) : 32'h0);
         chk("ram_wren", 32'(bus.ram_wren), 32'(e_wren[cyc]));
         if (e_wren[cyc]) chk("ram_data", bus.ram_data, e_wdata[cyc]);
         if (e_ra_v[cyc]) chk("ram_address", 32'(bus.ram_address), 32'(e_ra[cyc]));
         if (e_rom_v[cyc]) chk("rom_address", bus.rom_address, e_rom[cyc]);
         chk("busy", 32'(busy), 32'(e_busy[cyc]));
         chk("rw_conflict", 32'(rw_conflict), 32'(cyc >= conflict_from));
      end
   end

   task automatic step(input logic [2:0] ctl, input logic [31:0] m, d, p);
      @(posedge clock);
      #1;
      cyc++;
      mem_ctl = ctl; mar = m; mdr = d; pc = p;
      model_issue(cyc, ctl, m, d, p);
   endtask

   task automatic idle();
      step(3'b000, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic reset_zero_checks(input string tag);
      chk({tag, "_mdr_load"}, 32'(mdr_load), 32'h0);
      chk({tag, "_mdr_in"},   mdr_in, 32'h0);
      chk({tag, "_mbr_in"},   32'(mbr_in), 32'h0);
      chk({tag, "_ram_wren"}, 32'(bus.ram_wren), 32'h0);
      chk({tag, "_ram_addr"}, 32'(bus.ram_address), 32'h0);
      chk({tag, "_rom_addr"}, bus.rom_address, 32'h0);
      chk({tag, "_busy"},     32'(busy), 32'h0);
      chk({tag, "_rw_conf"},  32'(rw_conflict), 32'h0);
   endtask

   initial begin
      int k;
      mem_ctl = 3'b000; mar = '0; mdr = '0; pc = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 reset_zero_checks("por");
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      run_cmp = 1;

      tb_ram[30'h10]    = 32'hDEAD_BEEF;
      model_ram[30'h10] = 32'hDEAD_BEEF;

      // Read of a preloaded word: load only two cycles after issue
      step(3'b010, 32'h10, 32'h0, 32'h0); k = cyc;
      chk("model_rd_data", e_mdr[k+2], 32'hDEAD_BEEF);
      idle(); @(negedge clock); chk("rd_k1_load", 32'(mdr_load), 32'h0);
      idle(); @(negedge clock); chk("rd_k2_load", 32'(mdr_load), 32'h1);
                                chk("rd_k2_data", mdr_in, 32'hDEAD_BEEF);
      idle(); @(negedge clock); chk("rd_k3_load", 32'(mdr_load), 32'h0);

      // Four pipelined fetches across one ROM word, all byte lanes
      step(3'b001, 32'h0, 32'h0, 32'h20); k = cyc;
      chk("model_mbr0", 32'(e_mbr[k+2]), 32'h11);
      step(3'b001, 32'h0, 32'h0, 32'h21);
      step(3'b001, 32'h0, 32'h0, 32'h22); @(negedge clock); chk("fe_b0", 32'(mbr_in), 32'h11);
      step(3'b001, 32'h0, 32'h0, 32'h23); @(negedge clock); chk("fe_b1", 32'(mbr_in), 32'h22);
      chk("model_mbr3", 32'(e_mbr[k+5]), 32'h44);
      idle(); @(negedge clock); chk("fe_b2", 32'(mbr_in), 32'h33);
      idle(); @(negedge clock); chk("fe_b3", 32'(mbr_in), 32'h44);
                                chk("fe_b3_load", 32'(mbr_load), 32'h1);
      idle(); @(negedge clock); chk("fe_end_load", 32'(mbr_load), 32'h0);

      // Write then read-after-write to the same word
      step(3'b100, 32'h4, 32'hCAFE_0001, 32'h0);
      step(3'b010, 32'h4, 32'h0, 32'h0); @(negedge clock);
      chk("raw_wren1", 32'(bus.ram_wren), 32'h1);
      chk("raw_wdata", bus.ram_data, 32'hCAFE_0001);
      idle(); @(negedge clock); chk("raw_wren0", 32'(bus.ram_wren), 32'h0);
      idle(); @(negedge clock); chk("raw_data", mdr_in, 32'hCAFE_0001);

      // Read and fetch in the same microinstruction
      step(3'b011, 32'h10, 32'h0, 32'h21);
      idle();
      idle(); @(negedge clock);
      chk("par_mdr", mdr_in, 32'hDEAD_BEEF);
      chk("par_mbr", 32'(mbr_in), 32'h22);
      chk("par_both", {30'h0, mdr_load, mbr_load}, 32'h3);

      // Reset with a read in flight
      step(3'b010, 32'h10, 32'h0, 32'h0);
      idle(); @(negedge clock);
      #1 reset = 1'b0;
      model_reset();
      #1 reset_zero_checks("rst");
      idle();
      #2 reset = 1'b1;
      idle(); @(negedge clock);
      chk("rst_no_load", 32'(mdr_load), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // Read+write conflict: write wins, flag sticks
      step(3'b110, 32'h8, 32'h1234_5678, 32'h0);
      idle(); @(negedge clock);
      chk("cf_wren", 32'(bus.ram_wren), 32'h1);
      chk("cf_flag", 32'(rw_conflict), 32'h1);
      idle(); @(negedge clock);
      chk("cf_no_load", 32'(mdr_load), 32'h0);
      idle();

      // Random traffic
      for (int i = 0; i < 650; i++) begin
         logic [2:0]  c;
         logic [31:0] m, p;
         c = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         m = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
         p = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
         step(c, m, $urandom, p);
      end
      repeat (4) idle();
      @(negedge clock);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
